// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types for the word-serial adder
package add_pkg;

   typedef enum logic {FIRST, NEXT} add_ser_st_t;

endpackage

// File: rtl/add_word_serial_rca.sv
// rtl/add_word_serial_rca.sv - combinational ripple-carry adder, one word wide
module RCA #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   output logic [WIDTH-1:0] S,
   output logic             Co
);

   logic [WIDTH:0] c;

   always_comb begin
      c    = '0;
      S    = '0;
      c[0] = Ci;
      for (int i = 0; i < WIDTH; i++) begin
         S[i]   = A[i] ^ B[i] ^ c[i];
         c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
      end
   end

   assign Co = c[WIDTH];

endmodule

// File: rtl/add_word_serial.sv
// rtl/add_word_serial.sv - multi-word sequential adder around a single RCA
module add_word_serial
   import add_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_vld,
   output logic             i_rdy,
   input  logic [WIDTH-1:0] i_A,
   input  logic [WIDTH-1:0] i_B,
   input  logic             i_lst,
   input  logic             Ci,
   output logic             o_vld,
   input  logic             o_rdy,
   output logic [WIDTH-1:0] o_S,
   output logic             o_lst,
   output logic             Co,
   output logic             V
);

   add_ser_st_t      state_q, state_d;
   logic             carry_q, carry_d;
   logic             vld_q, vld_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             lst_q, lst_d;
   logic             co_q, co_d;
   logic             v_q, v_d;

   logic             accept;
   logic             rca_ci;
   logic [WIDTH-1:0] rca_s;
   logic             rca_co;

   assign i_rdy  = ~vld_q | o_rdy;
   assign accept = i_vld & i_rdy;
   // The carry register is ignored on the first beat so a previous transaction cannot leak in.
   assign rca_ci = (state_q == FIRST) ? Ci : carry_q;

   RCA #(.WIDTH(WIDTH)) u_rca (
      .A  (i_A),
      .B  (i_B),
      .Ci (rca_ci),
      .S  (rca_s),
      .Co (rca_co)
   );

   always_comb begin
      state_d = state_q;
      carry_d = carry_q;
      vld_d   = vld_q;
      s_d     = s_q;
      lst_d   = lst_q;
      co_d    = co_q;
      v_d     = v_q;
      if (accept) begin
         state_d = i_lst ? FIRST : NEXT;
         carry_d = rca_co;
         vld_d   = 1'b1;
         s_d     = rca_s;
         lst_d   = i_lst;
         co_d    = i_lst & rca_co;
         v_d     = i_lst & (i_A[WIDTH-1] == i_B[WIDTH-1]) & (rca_s[WIDTH-1] != i_A[WIDTH-1]);
      end else if (o_rdy) begin
         vld_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FIRST;
         carry_q <= 1'b0;
         vld_q   <= 1'b0;
         s_q     <= '0;
         lst_q   <= 1'b0;
         co_q    <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         vld_q   <= vld_d;
         s_q     <= s_d;
         lst_q   <= lst_d;
         co_q    <= co_d;
         v_q     <= v_d;
      end
   end

   assign o_vld = vld_q;
   assign o_S   = s_q;
   assign o_lst = lst_q;
   // Flags are forced low whenever they do not describe a valid final word.
   assign Co    = co_q & vld_q & lst_q;
   assign V     = v_q & vld_q & lst_q;

endmodule
